// File: rtl/spi_cmd_rx.sv
// SPI mode-0 slave that deframes MCU command packets (opcode, payload, XOR checksum)
// into the real-time command fields, the wcm write strobe and the time-init request.
module spi_cmd_rx #(
    parameter int WR_LEN      = 5,
    parameter int SYNC_STAGES = 2
) (
    input  logic        CLK,
    input  logic        rst_n,
    input  logic        SCK,
    input  logic        CS_n,
    input  logic        MOSI,
    output logic        MISO,
    input  logic        SYS_TIME_UPDATE_OK,
    output logic [47:0] FREQ,
    output logic [47:0] FREQ_STEP,
    output logic [31:0] FREQ_RATE,
    output logic [63:0] TIME_START,
    output logic [15:0] N_impulse,
    output logic [1:0]  TYPE_impulse,
    output logic [31:0] Interval_Ti,
    output logic [31:0] Interval_Tp,
    output logic [31:0] Tblank1,
    output logic [31:0] Tblank2,
    output logic        SPI_WR,
    output logic [63:0] TIME_INIT,
    output logic        SYS_TIME_UPDATE,
    output logic [7:0]  ERR_CNT
);
    localparam int WCW = $clog2(WR_LEN + 1);

    typedef enum logic [2:0] {IDLE, OPCODE, PAYLOAD, CHECK, COMMIT, DISCARD} state_t;
    state_t state, nxt;

    logic [SYNC_STAGES-1:0] sck_sr, cs_sr, mosi_sr;
    logic sck_d, cs_d, armed;
    logic [2:0]   bit_cnt;
    logic [7:0]   sh, op, xacc, miso_sh;
    logic [5:0]   byte_cnt;
    logic [343:0] shadow;
    logic         csum_ok;
    logic [WCW-1:0] wr_cnt;

    logic sck_s, cs_s, mosi_s, sck_rise, sck_fall, cs_rise, cs_fall, byte_done;
    logic err_hit, commit_go;
    logic [7:0] new_byte;
    logic [5:0] exp_len;

    assign sck_s     = sck_sr[SYNC_STAGES-1];
    assign cs_s      = cs_sr[SYNC_STAGES-1];
    assign mosi_s    = mosi_sr[SYNC_STAGES-1];
    assign sck_rise  = sck_s & ~sck_d;
    assign sck_fall  = ~sck_s & sck_d;
    assign cs_rise   = cs_s & ~cs_d;
    assign cs_fall   = ~cs_s & cs_d;
    assign byte_done = sck_rise && (bit_cnt == 3'd7);
    assign new_byte  = {sh[6:0], mosi_s};
    assign exp_len   = (op == 8'h01) ? 6'd43 : 6'd8;
    assign SPI_WR    = (wr_cnt != '0);
    assign MISO      = (state == OPCODE) & miso_sh[7];

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt;
    end

    // Any error exit from a live frame counts exactly once, on the way into DISCARD.
    always_comb begin
        nxt       = state;
        err_hit   = 1'b0;
        commit_go = 1'b0;
        case (state)
            IDLE:    if (armed && cs_fall) nxt = OPCODE;
            OPCODE:  if (cs_rise) begin
                         nxt = DISCARD; err_hit = 1'b1;
                     end else if (byte_done) begin
                         if (new_byte == 8'h01 || new_byte == 8'h02) nxt = PAYLOAD;
                         else begin nxt = DISCARD; err_hit = 1'b1; end
                     end
            PAYLOAD: if (cs_rise) begin
                         nxt = DISCARD; err_hit = 1'b1;
                     end else if (byte_done && byte_cnt == exp_len) nxt = CHECK;
            CHECK:   if (sck_rise) begin
                         nxt = DISCARD; err_hit = 1'b1;
                     end else if (cs_rise) begin
                         if (csum_ok) begin nxt = COMMIT; commit_go = 1'b1; end
                         else begin nxt = DISCARD; err_hit = 1'b1; end
                     end
            COMMIT:  nxt = IDLE;
            DISCARD: if (cs_s) nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            sck_sr <= '0; cs_sr <= '0; mosi_sr <= '0;
            sck_d <= 1'b0; cs_d <= 1'b0; armed <= 1'b0;
            bit_cnt <= '0; sh <= '0; op <= '0; xacc <= '0; miso_sh <= '0;
            byte_cnt <= '0; shadow <= '0; csum_ok <= 1'b0; wr_cnt <= '0;
            FREQ <= '0; FREQ_STEP <= '0; FREQ_RATE <= '0; TIME_START <= '0;
            N_impulse <= '0; TYPE_impulse <= '0; Interval_Ti <= '0; Interval_Tp <= '0;
            Tblank1 <= '0; Tblank2 <= '0; TIME_INIT <= '0;
            SYS_TIME_UPDATE <= 1'b0; ERR_CNT <= '0;
        end else begin
            sck_sr  <= {sck_sr[SYNC_STAGES-2:0], SCK};
            cs_sr   <= {cs_sr[SYNC_STAGES-2:0], CS_n};
            mosi_sr <= {mosi_sr[SYNC_STAGES-2:0], MOSI};
            sck_d   <= sck_s;
            cs_d    <= cs_s;
            // Reset-released with CS_n still low stays deaf until the bus goes idle.
            armed   <= armed | cs_s;

            if (state == IDLE) begin
                bit_cnt  <= '0;
                byte_cnt <= '0;
                xacc     <= '0;
            end else if (sck_rise) begin
                bit_cnt <= bit_cnt + 3'd1;
                sh      <= new_byte;
            end

            if (state == OPCODE && byte_done) op <= new_byte;

            if (state == PAYLOAD && byte_done) begin
                if (byte_cnt == exp_len) csum_ok <= (xacc == new_byte);
                else begin
                    shadow   <= {shadow[335:0], new_byte};
                    xacc     <= xacc ^ new_byte;
                    byte_cnt <= byte_cnt + 6'd1;
                end
            end

            if (state == IDLE && armed && cs_fall)
                miso_sh <= {SYS_TIME_UPDATE, SPI_WR, 2'b00, ERR_CNT[3:0]};
            else if (state == OPCODE && sck_fall)
                miso_sh <= {miso_sh[6:0], 1'b0};

            if (err_hit && ERR_CNT != 8'hFF) ERR_CNT <= ERR_CNT + 8'd1;

            // Fields land as the FSM enters COMMIT, so they are visible during cycle C.
            if (commit_go && op == 8'h01) begin
                FREQ         <= shadow[343:296];
                FREQ_STEP    <= shadow[295:248];
                FREQ_RATE    <= shadow[247:216];
                TIME_START   <= shadow[215:152];
                N_impulse    <= shadow[151:136];
                TYPE_impulse <= shadow[129:128];
                Interval_Ti  <= shadow[127:96];
                Interval_Tp  <= shadow[95:64];
                Tblank1      <= shadow[63:32];
                Tblank2      <= shadow[31:0];
            end
            if (commit_go && op == 8'h02) TIME_INIT <= shadow[63:0];

            if (state == COMMIT && op == 8'h01) wr_cnt <= WCW'(WR_LEN);
            else if (wr_cnt != '0)              wr_cnt <= wr_cnt - 1'b1;

            if (state == COMMIT && op == 8'h02) SYS_TIME_UPDATE <= 1'b1;
            else if (SYS_TIME_UPDATE_OK)        SYS_TIME_UPDATE <= 1'b0;
        end
    end
endmodule

// File: tb/tb_spi_cmd_rx.sv
// Directed bench for spi_cmd_rx: bit-banged SPI frames at CLK/8, hand-computed expectations.
module tb_spi_cmd_rx;
    logic CLK = 1'b0, rst_n = 1'b0, SCK = 1'b0, CS_n = 1'b1, MOSI = 1'b0, SYS_TIME_UPDATE_OK = 1'b0;
    logic        MISO, SPI_WR, SYS_TIME_UPDATE;
    logic [47:0] FREQ, FREQ_STEP;
    logic [31:0] FREQ_RATE, Interval_Ti, Interval_Tp, Tblank1, Tblank2;
    logic [63:0] TIME_START, TIME_INIT;
    logic [15:0] N_impulse;
    logic [1:0]  TYPE_impulse;
    logic [7:0]  ERR_CNT;

    int checks = 0, errors = 0;
    int lat, wid;
    logic [7:0] pl [0:42];
    logic [7:0] status;

    spi_cmd_rx #(.WR_LEN(5), .SYNC_STAGES(2)) dut (
        .CLK(CLK), .rst_n(rst_n), .SCK(SCK), .CS_n(CS_n), .MOSI(MOSI), .MISO(MISO),
        .SYS_TIME_UPDATE_OK(SYS_TIME_UPDATE_OK), .FREQ(FREQ), .FREQ_STEP(FREQ_STEP),
        .FREQ_RATE(FREQ_RATE), .TIME_START(TIME_START), .N_impulse(N_impulse),
        .TYPE_impulse(TYPE_impulse), .Interval_Ti(Interval_Ti), .Interval_Tp(Interval_Tp),
        .Tblank1(Tblank1), .Tblank2(Tblank2), .SPI_WR(SPI_WR), .TIME_INIT(TIME_INIT),
        .SYS_TIME_UPDATE(SYS_TIME_UPDATE), .ERR_CNT(ERR_CNT)
    );

    always #5 CLK = ~CLK;

    task automatic spi_byte(input logic [7:0] b, output logic [7:0] rx);
        for (int i = 7; i >= 0; i--) begin
            MOSI = b[i];
            #40; rx[i] = MISO; SCK = 1'b1;
            #40; SCK = 1'b0;
        end
        MOSI = 1'b0;
    endtask

    // n payload bytes; frame cut before byte 'cut' if cut < n; checksum XOR cmask; extra trailing bytes.
    task automatic send_frame(input logic [7:0] opc, input int n, input int cut,
                              input logic [7:0] cmask, input int extra);
        logic [7:0] x, rx;
        x = 8'h00;
        CS_n = 1'b0; #80;
        spi_byte(opc, status);
        for (int i = 0; i < n && i < cut; i++) begin spi_byte(pl[i], rx); x ^= pl[i]; end
        if (cut >= n) spi_byte(x ^ cmask, rx);
        for (int i = 0; i < extra; i++) spi_byte(8'h00, rx);
        #80; CS_n = 1'b1;
    endtask

    task automatic wait_wr();
        lat = -1; wid = 0;
        #1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge CLK);
            if (SPI_WR) begin wid++; if (lat < 0) lat = c; end
        end
    endtask

    task automatic fill_cmd(input logic [63:0] ts);
        logic [343:0] v;
        v = {48'h001000000000, 48'h000000100000, 32'h00000100, ts, 16'h0002, 8'hFD,
             32'h1800, 32'h1800, 32'h180, 32'h180};
        for (int i = 0; i < 43; i++) pl[i] = v[343-8*i -: 8];
    endtask

    task automatic test_reset();
        repeat (3) @(negedge CLK);
        checks++; if (FREQ !== 48'h0) begin errors++; $display("FAIL reset_freq got %h want 0", FREQ); end
        checks++; if (TIME_START !== 64'h0) begin errors++; $display("FAIL reset_time_start got %h want 0", TIME_START); end
        checks++; if (SPI_WR !== 1'b0) begin errors++; $display("FAIL reset_spi_wr got %b want 0", SPI_WR); end
        checks++; if (MISO !== 1'b0) begin errors++; $display("FAIL reset_miso got %b want 0", MISO); end
        checks++; if (ERR_CNT !== 8'h00) begin errors++; $display("FAIL reset_err got %h want 00", ERR_CNT); end
        checks++; if (SYS_TIME_UPDATE !== 1'b0) begin errors++; $display("FAIL reset_stu got %b want 0", SYS_TIME_UPDATE); end
        rst_n = 1'b1;
        repeat (5) @(negedge CLK);
    endtask

    task automatic test_command();
        fill_cmd(64'h12C0);
        send_frame(8'h01, 43, 99, 8'h00, 0);
        wait_wr();
        checks++; if (FREQ !== 48'h001000000000) begin errors++; $display("FAIL cmd_freq got %h want 001000000000", FREQ); end
        checks++; if (FREQ_STEP !== 48'h000000100000) begin errors++; $display("FAIL cmd_step got %h want 000000100000", FREQ_STEP); end
        checks++; if (FREQ_RATE !== 32'h100) begin errors++; $display("FAIL cmd_rate got %h want 100", FREQ_RATE); end
        checks++; if (TIME_START !== 64'h12C0) begin errors++; $display("FAIL cmd_time_start got %h want 12c0", TIME_START); end
        checks++; if (N_impulse !== 16'd2) begin errors++; $display("FAIL cmd_n got %0d want 2", N_impulse); end
        checks++; if (TYPE_impulse !== 2'd1) begin errors++; $display("FAIL cmd_type got %0d want 1", TYPE_impulse); end
        checks++; if (Interval_Ti !== 32'h1800 || Interval_Tp !== 32'h1800) begin errors++; $display("FAIL cmd_ti_tp got %h/%h want 1800/1800", Interval_Ti, Interval_Tp); end
        checks++; if (Tblank1 !== 32'h180 || Tblank2 !== 32'h180) begin errors++; $display("FAIL cmd_blank got %h/%h want 180/180", Tblank1, Tblank2); end
        checks++; if (wid !== 5) begin errors++; $display("FAIL cmd_wr_width got %0d want 5", wid); end
        checks++; if (lat < 1 || lat > 5) begin errors++; $display("FAIL cmd_wr_latency got %0d want 1..5", lat); end
        checks++; if (ERR_CNT !== 8'h00) begin errors++; $display("FAIL cmd_err got %h want 00", ERR_CNT); end
        checks++; if (status !== 8'h00) begin errors++; $display("FAIL cmd_status got %h want 00", status); end
    endtask

    task automatic test_bad_checksum();
        fill_cmd(64'h22C0);
        send_frame(8'h01, 43, 99, 8'h01, 0);
        wait_wr();
        checks++; if (TIME_START !== 64'h12C0) begin errors++; $display("FAIL badsum_time_start got %h want 12c0", TIME_START); end
        checks++; if (wid !== 0) begin errors++; $display("FAIL badsum_wr got %0d want 0", wid); end
        checks++; if (ERR_CNT !== 8'h01) begin errors++; $display("FAIL badsum_err got %h want 01", ERR_CNT); end
    endtask

    task automatic test_time_init();
        logic [63:0] ti;
        for (int i = 0; i < 8; i++) pl[i] = 8'h00;
        send_frame(8'h02, 8, 99, 8'h00, 0);
        wait_wr();
        checks++; if (SYS_TIME_UPDATE !== 1'b1) begin errors++; $display("FAIL ti_stu_set got %b want 1", SYS_TIME_UPDATE); end
        checks++; if (TIME_INIT !== 64'h0) begin errors++; $display("FAIL ti_zero got %h want 0", TIME_INIT); end
        checks++; if (wid !== 0) begin errors++; $display("FAIL ti_no_wr got %0d want 0", wid); end
        ti = 64'h0123456789ABCDEF;
        for (int i = 0; i < 8; i++) pl[i] = ti[63-8*i -: 8];
        send_frame(8'h02, 8, 99, 8'h00, 0);
        wait_wr();
        checks++; if (TIME_INIT !== 64'h0123456789ABCDEF) begin errors++; $display("FAIL ti_value got %h want 0123456789abcdef", TIME_INIT); end
        checks++; if (status !== 8'h81) begin errors++; $display("FAIL ti_status got %h want 81", status); end
        SYS_TIME_UPDATE_OK = 1'b1;
        #1;
        checks++; if (SYS_TIME_UPDATE !== 1'b1) begin errors++; $display("FAIL ti_stu_hold got %b want 1", SYS_TIME_UPDATE); end
        @(negedge CLK); SYS_TIME_UPDATE_OK = 1'b0;
        checks++; if (SYS_TIME_UPDATE !== 1'b0) begin errors++; $display("FAIL ti_stu_clear got %b want 0", SYS_TIME_UPDATE); end
    endtask

    task automatic test_frame_errors();
        fill_cmd(64'h22C0);
        send_frame(8'h01, 43, 20, 8'h00, 0);
        wait_wr();
        checks++; if (ERR_CNT !== 8'h02 || TIME_START !== 64'h12C0) begin errors++; $display("FAIL short_frame got err %h ts %h want 02 12c0", ERR_CNT, TIME_START); end
        send_frame(8'h7E, 0, 99, 8'h00, 0);
        wait_wr();
        checks++; if (ERR_CNT !== 8'h03 || TIME_START !== 64'h12C0) begin errors++; $display("FAIL bad_opcode got err %h ts %h want 03 12c0", ERR_CNT, TIME_START); end
        send_frame(8'h01, 43, 99, 8'h00, 1);
        wait_wr();
        checks++; if (ERR_CNT !== 8'h04 || wid !== 0) begin errors++; $display("FAIL extra_sck got err %h wr %0d want 04 0", ERR_CNT, wid); end
        send_frame(8'h01, 43, 99, 8'h00, 0);
        wait_wr();
        checks++; if (TIME_START !== 64'h22C0 || wid !== 5) begin errors++; $display("FAIL recover got ts %h wr %0d want 22c0 5", TIME_START, wid); end
        checks++; if (status !== 8'h04) begin errors++; $display("FAIL recover_status got %h want 04", status); end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] x, rx;
        fill_cmd(64'h3333);
        send_frame(8'h01, 43, 99, 8'h00, 0);
        for (int c = 0; c < 10 && !SPI_WR; c++) @(negedge CLK);
        checks++; if (SPI_WR !== 1'b1) begin errors++; $display("FAIL trunc_pre got %b want 1", SPI_WR); end
        rst_n = 1'b0; #1;
        checks++; if (SPI_WR !== 1'b0 || TIME_START !== 64'h0) begin errors++; $display("FAIL trunc_reset got wr %b ts %h want 0 0", SPI_WR, TIME_START); end
        #9; rst_n = 1'b1;
        repeat (5) @(negedge CLK);
        fill_cmd(64'h4444);
        x = 8'h00;
        CS_n = 1'b0; #80;
        spi_byte(8'h01, rx);
        for (int i = 0; i < 43; i++) begin
            if (i == 10) begin
                rst_n = 1'b0; #1;
                checks++; if (ERR_CNT !== 8'h00 || FREQ !== 48'h0) begin errors++; $display("FAIL midframe_reset got err %h freq %h want 0 0", ERR_CNT, FREQ); end
                #19; rst_n = 1'b1;
            end
            spi_byte(pl[i], rx); x ^= pl[i];
        end
        spi_byte(x, rx);
        #80; CS_n = 1'b1;
        wait_wr();
        checks++; if (TIME_START !== 64'h0 || wid !== 0 || ERR_CNT !== 8'h00) begin errors++; $display("FAIL unarmed got ts %h wr %0d err %h want 0 0 00", TIME_START, wid, ERR_CNT); end
        send_frame(8'h01, 43, 99, 8'h00, 0);
        wait_wr();
        checks++; if (TIME_START !== 64'h4444 || wid !== 5) begin errors++; $display("FAIL rearm got ts %h wr %0d want 4444 5", TIME_START, wid); end
    endtask

    task automatic test_saturation();
        logic [7:0] rx;
        for (int f = 0; f < 300; f++) begin
            CS_n = 1'b0; #80;
            spi_byte(8'h7E, rx);
            #80; CS_n = 1'b1; #80;
        end
        checks++; if (ERR_CNT !== 8'hFF) begin errors++; $display("FAIL saturate got %h want ff", ERR_CNT); end
        send_frame(8'h7E, 0, 0, 8'h00, 0);
        wait_wr();
        checks++; if (status !== 8'h0F) begin errors++; $display("FAIL sat_status got %h want 0f", status); end
        checks++; if (ERR_CNT !== 8'hFF) begin errors++; $display("FAIL sat_hold got %h want ff", ERR_CNT); end
    endtask

    initial begin
        test_reset();
        test_command();
        test_bad_checksum();
        test_time_init();
        test_frame_errors();
        test_reset_midframe();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
